// File: rtl/seq_alu.sv
// Sequential WIDTH-bit ALU with flags, signed SLT and valid/ready handshakes.
// Define ALU_MUL_EN to build op 110 as a multi-cycle shift-and-add multiplier.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state;

  if (WIDTH < 2 || CNT_W != $clog2(WIDTH) + 1) begin : g_param_check
  end

  logic [WIDTH-1:0] a_c, b_c;
  logic [WIDTH:0]   sum, diff;
  logic             ovf_sub;
  logic [WIDTH-1:0] c_res;
  logic             c_cout, c_ovf, c_ill;

  assign in_ready = (state == IDLE);

  // Single-cycle datapath; SLT reuses a' - b' and corrects the sign with ovf_sub.
  always_comb begin
    a_c     = ainv ? ~a : a;
    b_c     = binv ? ~b : b;
    sum     = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, cin};
    diff    = {1'b0, a_c} + {1'b0, ~b_c} + {{WIDTH{1'b0}}, 1'b1};
    ovf_sub = (a_c[WIDTH-1] != b_c[WIDTH-1]) && (diff[WIDTH-1] != a_c[WIDTH-1]);
    c_res   = '0;
    c_cout  = 1'b0;
    c_ovf   = 1'b0;
    c_ill   = 1'b0;
    case (op)
      3'b000: c_res = a_c & b_c;
      3'b001: c_res = a_c | b_c;
      3'b010: c_res = a_c ^ b_c;
      3'b011: c_res = ~(a_c | b_c);
      3'b100: begin
        c_res  = sum[WIDTH-1:0];
        c_cout = sum[WIDTH];
        c_ovf  = (a_c[WIDTH-1] == b_c[WIDTH-1]) && (sum[WIDTH-1] != a_c[WIDTH-1]);
      end
      3'b101: begin
        c_res  = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
        c_cout = diff[WIDTH];
        c_ovf  = ovf_sub;
      end
      default: c_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand, acc, acc_step, acc_last;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // The final step folds in the top two multiplier bits so the result lands WIDTH cycles after accept.
  always_comb begin
    acc_step = acc + (mplier[0] ? mcand : '0);
    acc_last = acc_step + (mplier[1] ? (mcand << 1) : '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MUL_EN
            if (op == 3'b110) begin
              mcand  <= {{WIDTH{1'b0}}, a_c};
              mplier <= b_c;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else
`endif
            begin
              result    <= c_res;
              cout      <= c_cout;
              overflow  <= c_ovf;
              zero      <= (c_res == '0);
              negative  <= c_res[WIDTH-1];
              illegal   <= c_ill;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (cnt == CNT_W'(WIDTH - 2)) begin
            result    <= acc_last[WIDTH-1:0];
            cout      <= |acc_last[2*WIDTH-1:WIDTH];
            overflow  <= 1'b0;
            zero      <= (acc_last[WIDTH-1:0] == '0);
            negative  <= acc_last[WIDTH-1];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8); MUL cases follow ALU_MUL_EN.
module tb_seq_alu;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       ainv, binv, cin;
  logic [2:0] op;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       cout, overflow, zero, negative, illegal;

  int tests_run = 0;
  int failures  = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ainv(ainv), .binv(binv), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero), .negative(negative),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, accepts one op, then counts cycles until out_valid.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tainv,
                               input logic tbinv, input logic tcin, input logic [2:0] top,
                               output int lat, output logic rdy_seen);
    int wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb; ainv = tainv; binv = tbinv; cin = tcin; op = top;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expectResult(input string tag, input logic [7:0] r, input logic c, input logic o,
                              input logic z, input logic n, input logic il);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_result"}, result, r);
    checkOutput({tag, "_cout"}, cout, c);
    checkOutput({tag, "_overflow"}, overflow, o);
    checkOutput({tag, "_zero"}, zero, z);
    checkOutput({tag, "_negative"}, negative, n);
    checkOutput({tag, "_illegal"}, illegal, il);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_after_release"}, out_valid, 0);
    checkOutput({tag, "_ready_after_release"}, in_ready, 1);
  endtask

  task automatic runOp(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tainv, input logic tbinv, input logic tcin, input logic [2:0] top,
                       input logic [7:0] r, input logic c, input logic o, input logic z,
                       input logic n, input logic il);
    int lat;
    logic rdy;
    applyStimulus(ta, tb, tainv, tbinv, tcin, top, lat, rdy);
    checkOutput({tag, "_latency"}, lat, 1);
    expectResult(tag, r, c, o, z, n, il);
    releaseResult(tag);
  endtask

  initial begin
    int lat;
    logic rdy;
    logic [7:0] held;
    logic pulse_seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_flags", {cout, overflow, zero, negative, illegal}, 5'b0);

    //    tag         a      b      ainv  binv  cin   op      res    c  o  z  n  il
    runOp("and_ainv", 8'h0F, 8'h3C, 1'b1, 1'b0, 1'b0, 3'b000, 8'h30, 0, 0, 0, 0, 0);
    runOp("or",       8'h50, 8'h0A, 1'b0, 1'b0, 1'b0, 3'b001, 8'h5A, 0, 0, 0, 0, 0);
    runOp("xor",      8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 3'b010, 8'hF0, 0, 0, 0, 1, 0);
    runOp("nor",      8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 3'b011, 8'h00, 0, 0, 1, 0, 0);
    runOp("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 3'b100, 8'h80, 0, 1, 0, 1, 0);
    runOp("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 3'b100, 8'h00, 1, 0, 1, 0, 0);
    runOp("sub",      8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 3'b100, 8'hFE, 0, 0, 0, 1, 0);
    runOp("slt_neg",  8'hFB, 8'h03, 1'b0, 1'b0, 1'b0, 3'b101, 8'h01, 1, 0, 0, 0, 0);
    runOp("slt_pos",  8'h03, 8'hFB, 1'b0, 1'b0, 1'b0, 3'b101, 8'h00, 0, 0, 1, 0, 0);
    runOp("slt_ovf",  8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 3'b101, 8'h01, 1, 1, 0, 0, 0);
    runOp("reserved", 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 3'b111, 8'h00, 0, 0, 1, 0, 1);

`ifdef ALU_MUL_EN
    applyStimulus(8'd13, 8'd11, 1'b0, 1'b0, 1'b0, 3'b110, lat, rdy);
    checkOutput("mul13_latency", lat, 8);
    checkOutput("mul13_ready_during_mul", rdy, 0);
    expectResult("mul13", 8'h8F, 0, 0, 0, 1, 0);
    releaseResult("mul13");
    applyStimulus(8'd16, 8'd16, 1'b0, 1'b0, 1'b0, 3'b110, lat, rdy);
    checkOutput("mul16_latency", lat, 8);
    expectResult("mul16", 8'h00, 1, 0, 1, 0, 0);
    releaseResult("mul16");
`else
    runOp("mul_disabled", 8'd13, 8'd11, 1'b0, 1'b0, 1'b0, 3'b110, 8'h00, 0, 0, 1, 0, 1);
`endif

    // Backpressure: hold the result while a competing op is offered.
    applyStimulus(8'hA5, 8'h0F, 1'b0, 1'b0, 1'b0, 3'b010, lat, rdy);
    checkOutput("bp_latency", lat, 1);
    held = result;
    checkOutput("bp_first_result", held, 8'hAA);
    a = 8'h01; b = 8'h01; op = 3'b100; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_result", result, 8'hAA);
      checkOutput("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checkOutput("bp_release_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("bp_ignored_op_valid", out_valid, 0);
    checkOutput("bp_ignored_op_result", result, 8'hAA);

    // Reset while busy must discard the operation without an out_valid pulse.
`ifdef ALU_MUL_EN
    a = 8'd13; b = 8'd11; ainv = 1'b0; binv = 1'b0; op = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`else
    a = 8'h10; b = 8'h20; ainv = 1'b0; binv = 1'b0; cin = 1'b0; op = 3'b100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("rst_pre_valid", out_valid, 1);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", {cout, overflow, zero, negative, illegal}, 5'b0);
    pulse_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) pulse_seen = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("rst_no_valid_pulse", pulse_seen, 0);

    runOp("post_rst_and", 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b0, 3'b000, 8'hAA, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
